uart_rx: RTL and testbench

UART receiver, the counterpart of the team's UART transmitter. Frame format is fixed: start bit 0, D_WIDTH data bits LSB first, one even-parity bit (XOR of the data bits), stop bit 1. The block samples RxD at CLKS_PER_BIT clocks per bit. It delivers each received word with error flags through a sticky valid/ack handshake. With CLKS_PER_BIT=1 it decodes the transmitter's one-bit-per-clock output directly, for on-chip loopback.

---
 rtl/uart_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for frames of start(0), D_WIDTH data bits LSB first,
// one even-parity bit and one stop bit(1), sampled at CLKS_PER_BIT clocks per bit.
// Received words are held in RX_data with parity/framing flags and announced
// through a sticky rx_valid that the consumer clears with rx_ack.
// Optional feature macro: UART_RX_SYNC_EN -- when defined, RxD passes through a
// two-flop synchronizer (reset value 1) before all other logic.
module uart_rx #(
  parameter int D_WIDTH      = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RxD,
  input  logic               rx_ack,
  output logic [D_WIDTH-1:0] RX_data,
  output logic               rx_valid,
  output logic               busy,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overrun_err
);

  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(D_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Even parity of a data word (XOR of all data bits).
  function automatic logic even_parity(input logic [D_WIDTH-1:0] word);
    even_parity = ^word;
  endfunction

  logic               rx_s;

  logic [2:0]         state_q, state_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [D_WIDTH-1:0] shift_q, shift_d;
  logic               par_q, par_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Next value of the two-stage synchronizer: raw line enters stage 0.
  always_comb begin
    sync_d = {sync_q[0], RxD};
  end

  // Synchronizer flops idle high so leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = RxD;
`endif

  // Frame FSM, bit sampling, and delivery of the word with its flags.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = 1'b0;
    if (rx_ack) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
        // Start detection only while armed: a line stuck low never starts a frame.
        if (armed_q && !rx_s) begin
          bit_idx_d = '0;
          if (HALF == 0) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            state_d = S_START;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            // Start bit vanished by mid-bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d              = shift_q >> 1;
          shift_d[D_WIDTH-1]   = rx_s;
          cnt_d                = '0;
          bit_idx_d            = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_LAST) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_d   = rx_s;
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          // Leave mid-stop-bit so a following start bit can be caught immediately.
          state_d = S_IDLE;
          cnt_d   = '0;
          data_d  = shift_q;
          perr_d  = (even_parity(shift_q) != par_q);
          ferr_d  = ~rx_s;
          if (!rx_s) begin
            armed_d = 1'b0;
          end else begin
            armed_d = armed_q;
          end
          // Completion wins over a same-cycle ack; overrun only if the old word was unacked.
          valid_d = 1'b1;
          ovr_d   = valid_q && !rx_ack;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign RX_data     = data_q;
  assign rx_valid    = valid_q;
  assign busy        = busy_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Two instances run side by side:
// index 0 at one clock per bit, index 1 at sixteen clocks per bit. Each sent
// frame pushes its expected word, flags, overrun and arrival cycle; a monitor
// pops and compares whenever a completion shows up on the outputs.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    logic        ovr;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxd   [2];
  logic        ack   [2];
  logic [7:0]  rdata [2];
  logic        valid [2];
  logic        busy  [2];
  logic        perr  [2];
  logic        ferr  [2];
  logic        ovr   [2];

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb [2][$];
  logic        vmodel [2];
  logic        vprev [2];
  logic        ovr_prev [2];
  logic        done_m;
  exp_t        e_m;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.D_WIDTH(8), .CLKS_PER_BIT(1)) u_dut_fast (
    .clk(clk), .rst(rst_n), .RxD(rxd[0]), .rx_ack(ack[0]),
    .RX_data(rdata[0]), .rx_valid(valid[0]), .busy(busy[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .overrun_err(ovr[0])
  );

  uart_rx #(.D_WIDTH(8), .CLKS_PER_BIT(16)) u_dut_slow (
    .clk(clk), .rst(rst_n), .RxD(rxd[1]), .rx_ack(ack[1]),
    .RX_data(rdata[1]), .rx_valid(valid[1]), .busy(busy[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .overrun_err(ovr[1])
  );

  function automatic int cpb(input int u);
    return (u == 0) ? 1 : 16;
  endfunction

  function automatic int half(input int u);
    return (cpb(u) - 1) / 2;
  endfunction

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: actual %0h required %0h (cycle %0d)", name, u, act, exp, cyc);
    end
  endtask

  // Monitor: a completion is a rising rx_valid or an overrun pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        vprev[u]    = 1'b0;
        ovr_prev[u] = 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (ovr_prev[u]) chk("overrun_pulse_width", u, {31'd0, ovr[u]}, 32'd0);
        done_m = (valid[u] && !vprev[u]) || ovr[u];
        if (done_m) begin
          if (sb[u].size() == 0) begin
            chk("unexpected_frame", u, {24'd0, rdata[u]}, 32'hFFFF_FFFF);
          end else begin
            e_m = sb[u].pop_front();
            chk("data",       u, {24'd0, rdata[u]}, {24'd0, e_m.data});
            chk("parity_err", u, {31'd0, perr[u]},  {31'd0, e_m.perr});
            chk("frame_err",  u, {31'd0, ferr[u]},  {31'd0, e_m.ferr});
            chk("overrun",    u, {31'd0, ovr[u]},   {31'd0, e_m.ovr});
            chk("valid",      u, {31'd0, valid[u]}, 32'd1);
            chk("busy_at_done", u, {31'd0, busy[u]}, 32'd0);
            chk("arrival_cycle", u, cyc, e_m.cyc);
          end
        end else if (sb[u].size() > 0 && cyc > sb[u][0].cyc) begin
          chk("missing_frame", u, cyc, sb[u][0].cyc);
          void'(sb[u].pop_front());
        end
        vprev[u]    = valid[u];
        ovr_prev[u] = ovr[u];
      end
    end
  end

  task automatic idle(input int u, input int k);
    repeat (k) begin
      @(posedge clk); #1;
      rxd[u] = 1'b1;
    end
  endtask

  // Send one frame; expected result is derived from the frame rules.
  task automatic send(input int u, input logic [7:0] d, input logic pflip,
                      input logic stopb, input logic ack_it);
    exp_t        e;
    logic [10:0] frame;
    frame = {stopb, (^d) ^ pflip, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < cpb(u); c++) begin
        @(posedge clk); #1;
        if (b == 0 && c == 0) begin
          e.data = d;
          e.perr = pflip;
          e.ferr = ~stopb;
          e.ovr  = vmodel[u] && !ack_it;
          e.cyc  = cyc + half(u) + 10 * cpb(u) + 1 + SYNC;
          sb[u].push_back(e);
          vmodel[u] = 1'b1;
        end
        rxd[u] = frame[b];
        ack[u] = ack_it && (b == 6) && (c == 0);
      end
    end
  endtask

  task automatic do_ack(input int u);
    @(posedge clk); #1;
    ack[u] = 1'b1;
    @(posedge clk); #1;
    ack[u] = 1'b0;
    @(negedge clk);
    chk("valid_after_ack", u, {31'd0, valid[u]}, 32'd0);
    vmodel[u] = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input int u);
    chk("rst_data",   u, {24'd0, rdata[u]}, 32'd0);
    chk("rst_valid",  u, {31'd0, valid[u]}, 32'd0);
    chk("rst_busy",   u, {31'd0, busy[u]},  32'd0);
    chk("rst_perr",   u, {31'd0, perr[u]},  32'd0);
    chk("rst_ferr",   u, {31'd0, ferr[u]},  32'd0);
    chk("rst_ovr",    u, {31'd0, ovr[u]},   32'd0);
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [10:0] frame;
    logic [7:0]  d;
    logic        pf, sbit, ak;
    int          gap, n;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rxd[u] = 1'b1; ack[u] = 1'b0; vmodel[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    idle(0, 3);
    idle(1, 3);

    // Clean 0xA5, then parity error on 0x01.
    send(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    wait_done();
    do_ack(0);
    send(0, 8'h01, 1'b1, 1'b1, 1'b0);
    wait_done();
    do_ack(0);

    // Framing error on 0x3C, line held low: no start may be detected.
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5 + SYNC; k++) begin
      @(posedge clk); #1;
      rxd[0] = 1'b0;
      @(negedge clk);
      if (k >= SYNC) chk("busy_low_hold", 0, {31'd0, busy[0]}, 32'd0);
    end
    idle(0, 2);
    send(0, 8'h55, 1'b0, 1'b1, 1'b1);
    wait_done();
    do_ack(0);

    // Back-to-back without ack: overrun on the second.
    send(0, 8'h11, 1'b0, 1'b1, 1'b0);
    send(0, 8'h22, 1'b0, 1'b1, 1'b0);
    wait_done();
    do_ack(0);

    // Reset during data bit 4 of 0x96, then a clean 0x96.
    idle(0, 2);
    d = 8'h96;
    frame = {1'b1, ^d, d, 1'b0};
    for (int b = 0; b < 6; b++) begin
      @(posedge clk); #1;
      rxd[0] = frame[b];
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rxd[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    rst_n = 1'b1;
    vmodel[0] = 1'b0;
    vmodel[1] = 1'b0;
    idle(0, 2);
    send(0, 8'h96, 1'b0, 1'b1, 1'b0);
    idle(0, 1);

    // Randomized frames on the fast instance.
    for (int i = 0; i < 40; i++) begin
      d    = 8'($urandom);
      pf   = ($urandom_range(7) == 0);
      sbit = ($urandom_range(7) != 0);
      ak   = 1'($urandom_range(1));
      gap  = $urandom_range(3);
      if (!sbit && gap == 0) gap = 1;
      send(0, d, pf, sbit, ak);
      idle(0, gap);
    end
    wait_done();

    // Glitch rejection on the slow instance.
    n = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      rxd[1] = (k < 3) ? 1'b0 : 1'b1;
      if (k == 0) n = cyc;
      @(negedge clk);
      if (cyc == n + 1 + SYNC)        chk("glitch_busy_start", 1, {31'd0, busy[1]}, 32'd1);
      if (cyc == n + half(1) + SYNC)  chk("glitch_busy_check", 1, {31'd0, busy[1]}, 32'd1);
      if (cyc == n + half(1) + 1 + SYNC) chk("glitch_busy_end", 1, {31'd0, busy[1]}, 32'd0);
    end
    chk("glitch_no_valid", 1, {31'd0, valid[1]}, 32'd0);
    idle(1, 4);
    send(1, 8'hC3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d    = 8'($urandom);
      pf   = ($urandom_range(3) == 0);
      sbit = ($urandom_range(3) != 0);
      ak   = 1'($urandom_range(1));
      send(1, d, pf, sbit, ak);
      idle(1, $urandom_range(2) + (sbit ? 0 : 1));
    end
    wait_done();

    repeat (5) @(posedge clk);
    chk("queue_empty", 0, sb[0].size(), 32'd0);
    chk("queue_empty", 1, sb[1].size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
